mem_responder: RTL and testbench

- Memory-side endpoint of the CPU memory interface. It is the responder to the core's request/response pair after the arbiter.
- Accepts word-address read requests on a decoupled input and services them from an internal word-addressed RAM.
- Returns in-order responses (address plus data) on a decoupled output after a programmable fixed latency.
- Used as the simulation/FPGA main memory behind the arbiter. It also has a backdoor load port for program preload.

---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_resp_queue.sv | 103 ++++++++++
 rtl/mem_responder.sv | 65 ++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_responder_pkg;

    // Byte address as seen on the memory bus.
    typedef logic [31:0] addr_t;

    // Response transaction: echoed request address in the upper word, read data below.
    typedef struct packed {
        addr_t       a;
        logic [31:0] data;
    } mtrans_t;

    // Width of the per-entry latency countdown (LATENCY is limited to 1..15).
    localparam int MEM_DLY_W = 4;
    typedef logic [MEM_DLY_W-1:0] dly_t;

    // Pattern returned for any address that does not decode to a RAM word.
    localparam logic [31:0] MEM_OOR_DATA = 32'hDEAD_BEEF;

    // Unsigned 32-bit offset of an address from the RAM base; addresses below
    // the base wrap to large offsets and therefore decode as out-of-range.
    function automatic addr_t mem_offset(input addr_t addr, input addr_t base);
        return addr - base;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the arbiter (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_responder_pkg::*;

    // Request channel: word-aligned byte address, decoupled.
    logic    req_valid;
    logic    req_ready;
    addr_t   req_addr;

    // Response channel: {addr, data}, decoupled.
    logic    resp_valid;
    logic    resp_ready;
    mtrans_t resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        output resp_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data,
        input  resp_ready
    );

endinterface

// File: rtl/mem_resp_queue.sv
// In-order response queue: circular buffer where every entry carries its own
// latency countdown; the head is presented once its countdown has expired.
module mem_resp_queue
    import mem_responder_pkg::*;
#(
    parameter int  QUEUE_DEPTH = 4,
    parameter int  LATENCY     = 2,
    parameter type T           = mtrans_t
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enq_valid,
    output logic o_enq_ready,
    input  T     i_enq_data,
    output logic o_deq_valid,
    input  logic i_deq_ready,
    output T     o_deq_data
);

    localparam int               PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(QUEUE_DEPTH - 1);
    localparam dly_t             INIT_DLY = MEM_DLY_W'(LATENCY - 1);

    T                 r_data [QUEUE_DEPTH];
    dly_t             r_dly  [QUEUE_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_enq;
    logic             w_deq;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    // Explicit wrap keeps a single-entry queue correct, where the 1-bit
    // pointer would otherwise step to a nonexistent entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered occupancy, so a dequeue in the same
    // cycle never frees a slot for the incoming request.
    assign o_enq_ready = (r_count != FULL);
    assign o_deq_valid = (r_count != '0) && (r_dly[r_head] == '0);
    assign o_deq_data  = r_data[r_head];

    assign w_enq = i_enq_valid && o_enq_ready;
    assign w_deq = o_deq_valid && i_deq_ready;

    // Next pointer and occupancy values from this cycle's enqueue/dequeue.
    always_comb begin
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        if (w_enq) begin
            w_tail_nxt = ptr_inc(r_tail);
        end
        if (w_deq) begin
            w_head_nxt = ptr_inc(r_head);
        end
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Control state: pointers, occupancy and per-entry countdowns. Free entries
    // also count down, which is harmless because enqueue reloads the countdown
    // and a free entry is never presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (w_enq && (r_tail == PTR_W'(i))) begin
                    r_dly[i] <= INIT_DLY;
                end else if (r_dly[i] != '0) begin
                    r_dly[i] <= r_dly[i] - 1'b1;
                end
            end
        end
    end

    // Payload capture at the tail; payload needs no reset since occupancy gates it.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_data[r_tail] <= i_enq_data;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Main-memory endpoint behind the arbiter: word-addressed RAM with a backdoor
// preload port, answering read requests in order after a fixed latency.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          WORDS       = 4096,
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          LATENCY     = 2,
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [31:0] OOR_DATA    = MEM_OOR_DATA
) (
    input  logic                     clk,
    input  logic                     rst,
    mem_responder_if.slave           mem_if,
    input  logic                     i_ld_en,
    input  logic [$clog2(WORDS)-1:0] i_ld_idx,
    input  logic [31:0]              i_ld_data
);

    localparam int          IDX_W = $clog2(WORDS);
    // Mapped window size in bytes, one bit wider so large WORDS cannot overflow.
    localparam logic [32:0] SPAN  = 33'(WORDS) << 2;

    logic [31:0] r_ram [WORDS];

    addr_t       w_offset;
    logic        w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [31:0] w_rd_data;
    mtrans_t     w_enq_data;

    // Address decode: the low two offset bits take part in the range test but
    // never select a word, so byte offsets within a word are ignored.
    assign w_offset   = mem_offset(mem_if.req_addr, BASE);
    assign w_in_range = ({1'b0, w_offset} < SPAN);
    assign w_idx      = w_offset[IDX_W+1:2];

    // Combinational read at accept time; a backdoor write in the same cycle
    // lands at the edge, so the request sees the old contents.
    assign w_rd_data  = w_in_range ? r_ram[w_idx] : OOR_DATA;
    assign w_enq_data = '{a: mem_if.req_addr, data: w_rd_data};

    // Backdoor preload; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            r_ram[i_ld_idx] <= i_ld_data;
        end
    end

    mem_resp_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .LATENCY     (LATENCY),
        .T           (mtrans_t)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_enq_valid (mem_if.req_valid),
        .o_enq_ready (mem_if.req_ready),
        .i_enq_data  (w_enq_data),
        .o_deq_valid (mem_if.resp_valid),
        .i_deq_ready (mem_if.resp_ready),
        .o_deq_data  (mem_if.resp_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of single reads plus hand sequences
// for streaming, backpressure, backdoor collision and reset mid-flight.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clk;
    logic        rst = 1'b1;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t vecs [6];

    mem_responder_if bus ();

    mem_responder #(
        .WORDS       (4096),
        .BASE        (32'h0000_0000),
        .LATENCY     (2),
        .QUEUE_DEPTH (4),
        .OOR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_if    (bus.slave),
        .i_ld_en   (ld_en),
        .i_ld_idx  (ld_idx),
        .i_ld_data (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = 12'(idx); ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // One request with resp_ready held high; checks latency, payload and one-cycle pulse.
    task automatic do_single(input logic [31:0] a, input logic [31:0] d, input string nm);
        int  k;
        bit  seen;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_addr = a;
        @(negedge clk);
        chk({nm, " req_ready"}, 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        k = 0; seen = 0;
        while (!seen && k < 12) begin
            @(negedge clk);
            k++;
            if (bus.resp_valid) seen = 1;
        end
        chk({nm, " latency"}, 64'(k), 64'd2);
        chk({nm, " data"}, bus.resp_data, {a, d});
        @(negedge clk);
        chk({nm, " one-cycle"}, 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        int got, first, last, drops, k, stale;

        vecs[0] = '{32'h0000_000C, 32'h1234_5678};
        vecs[1] = '{32'h0000_000D, 32'h1234_5678};
        vecs[2] = '{32'h0000_0010, 32'hC0DE_4444};
        vecs[3] = '{32'h0000_3FFC, 32'h0BAD_F00D};
        vecs[4] = '{32'h0000_4000, 32'hDEAD_BEEF};
        vecs[5] = '{32'hFFFF_FFFC, 32'hDEAD_BEEF};

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b1;
        ld_en = 1'b0; ld_idx = '0; ld_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset resp_valid", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 64'(bus.req_ready), 64'd1);
        chk("post-reset resp_valid", 64'(bus.resp_valid), 64'd0);

        // Streaming: 16 back-to-back reads of a preloaded pattern
        for (int i = 0; i < 16; i++) load(i, pat(i));
        bus.resp_ready = 1'b1;
        got = 0; first = -1; last = -1; drops = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            bus.req_valid = (c < 16);
            bus.req_addr  = 32'(c) * 32'd4;
            @(negedge clk);
            if (c < 16 && !bus.req_ready) drops++;
            if (bus.resp_valid) begin
                if (got < 16) chk("stream data", bus.resp_data, {32'(got) * 32'd4, pat(got)});
                if (first < 0) first = c;
                last = c;
                got++;
            end
        end
        bus.req_valid = 1'b0;
        chk("stream count", 64'(got), 64'd16);
        chk("stream first cycle", 64'(first), 64'd2);
        chk("stream contiguous", 64'(last - first + 1), 64'd16);
        chk("stream ready drops", 64'(drops), 64'd0);

        // Table of single reads, including out-of-range and last word
        load(3, 32'h1234_5678);
        load(4095, 32'h0BAD_F00D);
        for (int v = 0; v < 6; v++) begin
            do_single(vecs[v].addr, vecs[v].data, $sformatf("vec%0d", v));
        end

        // Backpressure: 6 offered while the output is stalled
        bus.resp_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            bus.req_valid = (k < 6);
            bus.req_addr  = 32'h20 + 32'(k) * 32'd4;
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) k++;
            if (c >= 5) begin
                chk("bp stall valid", 64'(bus.resp_valid), 64'd1);
                chk("bp stall data", bus.resp_data, {32'h20, pat(8)});
            end
        end
        chk("bp accepted", 64'(k), 64'd4);
        chk("bp req_ready full", 64'(bus.req_ready), 64'd0);
        got = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            bus.resp_ready = 1'b1;
            bus.req_valid  = (k < 6);
            bus.req_addr   = 32'h20 + 32'(k) * 32'd4;
            @(negedge clk);
            if (bus.req_valid && bus.req_ready) k++;
            if (bus.resp_valid) begin
                if (got < 6) chk("bp drain data", bus.resp_data,
                                 {32'h20 + 32'(got) * 32'd4, pat(8 + got)});
                got++;
            end
        end
        bus.req_valid = 1'b0;
        chk("bp total accepted", 64'(k), 64'd6);
        chk("bp total responses", 64'(got), 64'd6);

        // Backdoor collision: same-cycle write returns old data
        load(5, 32'hAAAA_AAAA);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_idx = 12'd5; ld_data = 32'h5555_5555;
        bus.req_valid = 1'b1; bus.req_addr = 32'h14;
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (got == 0) chk("collide first", bus.resp_data, {32'h14, 32'hAAAA_AAAA});
                if (got == 1) chk("collide second", bus.resp_data, {32'h14, 32'h5555_5555});
                got++;
            end
        end
        chk("collide count", 64'(got), 64'd2);

        // Reset with three requests outstanding
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b1; bus.req_addr = 32'(i) * 32'd4;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst pre valid", 64'(bus.resp_valid), 64'd1);
        #2 rst = 1'b1;
        #1 chk("rst valid drop", 64'(bus.resp_valid), 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.resp_valid) stale++;
        end
        chk("rst stale responses", 64'(stale), 64'd0);
        chk("rst req_ready", 64'(bus.req_ready), 64'd1);
        do_single(32'h0000_000C, 32'h1234_5678, "post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
